sync_fifo_ctl: RTL and testbench
================================

Name: sync_fifo_ctl

Overview:
Parametrised successor to the team's basic synchronous FIFO. Single-clock buffer with:
- arbitrary (non-power-of-two) depth
- selectable read mode: registered or first-word-fall-through
- programmable almost-full/almost-empty thresholds
- live occupancy count
- synchronous flush
- sticky overflow/underflow error flags

Sits between producer/consumer blocks in testbench and RTL datapaths wherever back-pressure and early warning are needed.

Parameters:
DATA_WIDTH, 8, width of each stored word (>=1)
DEPTH, 16, number of entries (>=2, need not be a power of two)
FWFT, 0, read mode: 0 = registered read (1-cycle latency), 1 = first-word-fall-through
AF_THRESH, DEPTH-2, almost_full asserted when count >= AF_THRESH (1..DEPTH)
AE_THRESH, 2, almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)

Ports:
clk  input  1  single clock, all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
flush  input  1  synchronous clear of FIFO contents and error flags
wr_en  input  1  write request
wr_data  input  DATA_WIDTH  write data
rd_en  input  1  read request
rd_data  output  DATA_WIDTH  read data
rd_valid  output  1  rd_data holds a valid word (meaning is mode-dependent, see Behaviour)
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_THRESH
almost_empty  output  1  count <= AE_THRESH
count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH
overflow  output  1  sticky: a write was attempted while full
underflow  output  1  sticky: a read was attempted while empty

Behaviour:
- Reset (rst_n low, asynchronous): wr_ptr, rd_ptr and count go to 0; rd_data 0; rd_valid 0; overflow 0; underflow 0. Hence empty=1, full=0, almost_empty=1, almost_full=0. Reset mid-transfer discards all contents. Memory array is not reset.
- Write accept: wr_acc = wr_en && !full && !flush. Word is stored at wr_ptr; wr_ptr advances.
- Read accept: rd_acc = rd_en && !empty && !flush. rd_ptr advances.
- Pointer wrap: explicit compare. DEPTH-1 -> 0. No modulo, no power-of-two assumption.
- Count update:
  - both accepted: unchanged
  - write only: +1
  - read only: -1
  - never exceeds DEPTH, never below 0
- Simultaneous events:
  - When full with wr_en && rd_en: read accepted, write rejected, overflow set, count -> DEPTH-1.
  - When empty with both asserted: write accepted, read rejected, underflow set, count -> 1. In FWFT mode the word is visible next cycle.
- Flag timing: full, empty, almost_* are decoded from registered count and change the cycle after the accepting edge.
- Errors: overflow sets on any edge where wr_en && full && !flush; underflow on rd_en && empty && !flush. Both hold until flush or reset.
- Flush: synchronous, highest priority over wr_en/rd_en. Pointers, count, overflow, underflow and rd_valid are cleared. rd_data holds its last value in FWFT=0. Memory is not cleared.
- FWFT=0:
  - rd_data is registered; it loads mem[rd_ptr] on the edge of rd_acc and otherwise holds.
  - rd_valid is a 1-cycle pulse in the cycle after rd_acc.
- FWFT=1:
  - rd_data = mem[rd_ptr] combinationally when !empty, else 0.
  - rd_valid = !empty.
  - A word written at edge N appears on rd_data after edge N (zero added latency).
  - rd_en acts as a pop/acknowledge.
- Thresholds: out-of-range parameter values are a fatal elaboration error (static assertion).

Test Plan:
Configuration: DATA_WIDTH=8, DEPTH=5, AF_THRESH=4, AE_THRESH=1, run in both FWFT modes unless noted.
1. Reset then write 0x11..0x15 on 5 consecutive cycles.
   - count 1..5
   - almost_empty drops when count reaches 2
   - almost_full rises at count 4
   - full rises at count 5
   - 6th write 0x16: count stays 5, overflow=1
2. Read all 5 words.
   - data 0x11..0x15 in order
   - FWFT=0: each word appears one cycle after rd_en with a rd_valid pulse
   - FWFT=1: 0x11 is present before the first rd_en
   - empty=1 at end
   - extra rd_en sets underflow=1
3. Wrap-around: 3 writes, 3 reads, then 5 writes 0xA0..0xA4 and 5 reads.
   - pointers wrap 4 -> 0
   - data returned in order 0xA0..0xA4
4. Simultaneous: full FIFO with wr_en=rd_en=1 for one cycle.
   - count 4, oldest word read, overflow=1
   - empty FIFO with both asserted: count 1, underflow=1; word visible next cycle in FWFT=1
5. Flush with 3 words stored plus flags set, wr_en=1 in the same cycle.
   - next cycle: count 0, empty=1, overflow=underflow=0, write ignored
6. Assert rst_n=0 asynchronously mid-burst (between edges) with count 3.
   - outputs clear immediately without a clock edge
   - after release, first write/read returns the new data

Source files
------------

// File: rtl/sync_fifo_ctl.sv
// Single-clock FIFO controller with arbitrary depth, registered or first-word-fall-through read,
// programmable almost-full/almost-empty thresholds, synchronous flush and sticky error flags.
module sync_fifo_ctl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned FWFT       = 0,
    parameter int unsigned AF_THRESH  = DEPTH - 2,
    parameter int unsigned AE_THRESH  = 2,
    localparam int unsigned CW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic [CW-1:0]         count_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FullCnt = CW'(DEPTH);
    localparam logic [CW-1:0] AfCnt   = CW'(AF_THRESH);
    localparam logic [CW-1:0] AeCnt   = CW'(AE_THRESH);
    localparam logic [AW-1:0] LastPtr = AW'(DEPTH - 1);

    if (DATA_WIDTH < 1 || DEPTH < 2 || FWFT > 1 || AF_THRESH < 1 || AF_THRESH > DEPTH ||
        AE_THRESH > DEPTH - 1) begin : g_param_check
        $fatal(1, "sync_fifo_ctl: parameter out of range");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  wr_acc, rd_acc;

    // Depth need not be a power of two, so wrap by explicit compare.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LastPtr) ? '0 : p + AW'(1);
    endfunction

    assign full_o         = (count_q == FullCnt);
    assign empty_o        = (count_q == '0);
    assign almost_full_o  = (count_q >= AfCnt);
    assign almost_empty_o = (count_q <= AeCnt);
    assign count_o        = count_q;
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;

    assign wr_acc = wr_en_i && !full_o && !flush_i;
    assign rd_acc = rd_en_i && !empty_o && !flush_i;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (flush_i) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (rd_acc) rd_ptr_d = ptr_inc(rd_ptr_q);
            unique case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (wr_en_i && full_o)  overflow_d  = 1'b1;
            if (rd_en_i && empty_o) underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= wr_data_i;
    end

    if (FWFT != 0) begin : g_fwft
        assign rd_data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
        assign rd_valid_o = !empty_o;
    end else begin : g_reg
        logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
        logic                  rd_valid_q, rd_valid_d;

        // rd_data holds across flush; only the valid pulse is cleared.
        always_comb begin
            rd_data_d  = rd_data_q;
            rd_valid_d = rd_acc;
            if (rd_acc) rd_data_d = mem_q[rd_ptr_q];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_data_q  <= rd_data_d;
                rd_valid_q <= rd_valid_d;
            end
        end

        assign rd_data_o  = rd_data_q;
        assign rd_valid_o = rd_valid_q;
    end

endmodule

// File: tb/tb_sync_fifo_ctl.sv
// Drives a registered-read and an FWFT instance with identical stimulus and compares both
// against a queue-based reference model.
module tb_sync_fifo_ctl;

    localparam int unsigned Depth = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = '0;
    logic       rd_en = 1'b0;

    logic [7:0] r_rd_data, f_rd_data;
    logic       r_rd_valid, f_rd_valid;
    logic       r_full, f_full, r_empty, f_empty;
    logic       r_af, f_af, r_ae, f_ae;
    logic [2:0] r_count, f_count;
    logic       r_ovf, f_ovf, r_udf, f_udf;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] q[$];
    bit         m_ovf, m_udf, m_rvalid;
    logic [7:0] m_rdata;

    always #5 clk = ~clk;

    sync_fifo_ctl #(
        .DATA_WIDTH(8), .DEPTH(Depth), .FWFT(0), .AF_THRESH(4), .AE_THRESH(1)
    ) dut_r (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .wr_en_i(wr_en), .wr_data_i(wr_data),
        .rd_en_i(rd_en), .rd_data_o(r_rd_data), .rd_valid_o(r_rd_valid), .full_o(r_full),
        .empty_o(r_empty), .almost_full_o(r_af), .almost_empty_o(r_ae), .count_o(r_count),
        .overflow_o(r_ovf), .underflow_o(r_udf)
    );

    sync_fifo_ctl #(
        .DATA_WIDTH(8), .DEPTH(Depth), .FWFT(1), .AF_THRESH(4), .AE_THRESH(1)
    ) dut_f (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .wr_en_i(wr_en), .wr_data_i(wr_data),
        .rd_en_i(rd_en), .rd_data_o(f_rd_data), .rd_valid_o(f_rd_valid), .full_o(f_full),
        .empty_o(f_empty), .almost_full_o(f_af), .almost_empty_o(f_ae), .count_o(f_count),
        .overflow_o(f_ovf), .underflow_o(f_udf)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 0;
        m_udf = 0;
        m_rvalid = 0;
        m_rdata = '0;
    endtask

    task automatic model_step(input bit w, input logic [7:0] wd, input bit r, input bit f);
        bit was_full;
        bit was_empty;
        was_full  = (q.size() == Depth);
        was_empty = (q.size() == 0);
        if (f) begin
            q.delete();
            m_ovf = 0;
            m_udf = 0;
            m_rvalid = 0;
        end else begin
            if (w && was_full) m_ovf = 1;
            if (r && was_empty) m_udf = 1;
            m_rvalid = 0;
            if (r && !was_empty) begin
                m_rdata = q.pop_front();
                m_rvalid = 1;
            end
            if (w && !was_full) q.push_back(wd);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        check_eq({tag, ".r.count"}, 32'(r_count), n);
        check_eq({tag, ".f.count"}, 32'(f_count), n);
        check_eq({tag, ".r.full"}, 32'(r_full), 32'(n == Depth));
        check_eq({tag, ".f.full"}, 32'(f_full), 32'(n == Depth));
        check_eq({tag, ".r.empty"}, 32'(r_empty), 32'(n == 0));
        check_eq({tag, ".f.empty"}, 32'(f_empty), 32'(n == 0));
        check_eq({tag, ".r.afull"}, 32'(r_af), 32'(n >= 4));
        check_eq({tag, ".f.afull"}, 32'(f_af), 32'(n >= 4));
        check_eq({tag, ".r.aempty"}, 32'(r_ae), 32'(n <= 1));
        check_eq({tag, ".f.aempty"}, 32'(f_ae), 32'(n <= 1));
        check_eq({tag, ".r.ovf"}, 32'(r_ovf), 32'(m_ovf));
        check_eq({tag, ".f.ovf"}, 32'(f_ovf), 32'(m_ovf));
        check_eq({tag, ".r.udf"}, 32'(r_udf), 32'(m_udf));
        check_eq({tag, ".f.udf"}, 32'(f_udf), 32'(m_udf));
        check_eq({tag, ".r.rdata"}, 32'(r_rd_data), 32'(m_rdata));
        check_eq({tag, ".r.rvalid"}, 32'(r_rd_valid), 32'(m_rvalid));
        check_eq({tag, ".f.rdata"}, 32'(f_rd_data), (n > 0) ? 32'(q[0]) : 32'd0);
        check_eq({tag, ".f.rvalid"}, 32'(f_rd_valid), 32'(n > 0));
    endtask

    task automatic cycle(input string tag, input bit w, input logic [7:0] wd, input bit r,
                         input bit f);
        @(negedge clk);
        wr_en = w;
        wr_data = wd;
        rd_en = r;
        flush = f;
        @(posedge clk);
        model_step(w, wd, r, f);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        wr_en = 0;
        rd_en = 0;
        flush = 0;
        rst_n = 0;
        model_reset();
        #1;
        check_all("rst");
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        #2;
        rst_n = 0;
        model_reset();
        #1;
        check_all(tag);
        @(negedge clk);
        wr_en = 0;
        rd_en = 0;
        flush = 0;
        rst_n = 1;
    endtask

    initial begin
        model_reset();
        #1;
        check_all("init");
        do_reset();

        // 1: fill, thresholds, overflow
        for (int i = 0; i < 5; i++) cycle("t1.wr", 1, 8'(8'h11 + i), 0, 0);
        check_eq("t1.full", 32'(r_full), 1);
        cycle("t1.ovf", 1, 8'h16, 0, 0);
        check_eq("t1.ovf_set", 32'(f_ovf), 1);
        check_eq("t1.count5", 32'(r_count), 5);

        // 2: drain in order, then underflow
        check_eq("t2.fwft_first", 32'(f_rd_data), 32'h11);
        for (int i = 0; i < 5; i++) begin
            cycle("t2.rd", 0, 8'h00, 1, 0);
            check_eq("t2.r.data", 32'(r_rd_data), 32'(8'h11 + i));
            check_eq("t2.r.valid", 32'(r_rd_valid), 1);
        end
        check_eq("t2.empty", 32'(f_empty), 1);
        cycle("t2.udf", 0, 8'h00, 1, 0);
        check_eq("t2.udf_set", 32'(r_udf), 1);

        // 3: wrap-around
        do_reset();
        for (int i = 0; i < 3; i++) cycle("t3.wr", 1, 8'(8'h30 + i), 0, 0);
        for (int i = 0; i < 3; i++) cycle("t3.rd", 0, 8'h00, 1, 0);
        for (int i = 0; i < 5; i++) cycle("t3.wrap_wr", 1, 8'(8'hA0 + i), 0, 0);
        for (int i = 0; i < 5; i++) begin
            check_eq("t3.f.data", 32'(f_rd_data), 32'(8'hA0 + i));
            cycle("t3.wrap_rd", 0, 8'h00, 1, 0);
            check_eq("t3.r.data", 32'(r_rd_data), 32'(8'hA0 + i));
        end

        // 4: simultaneous read/write at full and at empty
        do_reset();
        for (int i = 0; i < 5; i++) cycle("t4.wr", 1, 8'(8'h40 + i), 0, 0);
        cycle("t4.full_rw", 1, 8'h55, 1, 0);
        check_eq("t4.count4", 32'(r_count), 4);
        check_eq("t4.oldest", 32'(r_rd_data), 32'h40);
        check_eq("t4.ovf", 32'(r_ovf), 1);
        for (int i = 0; i < 4; i++) cycle("t4.rd", 0, 8'h00, 1, 0);
        cycle("t4.empty_rw", 1, 8'h66, 1, 0);
        check_eq("t4.count1", 32'(f_count), 1);
        check_eq("t4.udf", 32'(f_udf), 1);
        check_eq("t4.fwft_vis", 32'(f_rd_data), 32'h66);

        // 5: flush with data and flags, concurrent write ignored
        do_reset();
        cycle("t5.udf", 0, 8'h00, 1, 0);
        for (int i = 0; i < 6; i++) cycle("t5.wr", 1, 8'(8'h50 + i), 0, 0);
        cycle("t5.rd", 0, 8'h00, 1, 0);
        cycle("t5.rd", 0, 8'h00, 1, 0);
        check_eq("t5.pre_count", 32'(r_count), 3);
        cycle("t5.flush", 1, 8'h99, 0, 1);
        check_eq("t5.count0", 32'(f_count), 0);
        check_eq("t5.empty", 32'(r_empty), 1);
        check_eq("t5.ovf0", 32'(r_ovf), 0);
        check_eq("t5.udf0", 32'(f_udf), 0);
        cycle("t5.idle", 0, 8'h00, 0, 0);

        // 6: asynchronous reset mid-burst
        do_reset();
        for (int i = 0; i < 3; i++) cycle("t6.wr", 1, 8'(8'h60 + i), 0, 0);
        cycle("t6.rd", 0, 8'h00, 1, 0);
        cycle("t6.wr", 1, 8'h63, 0, 0);
        async_reset("t6.arst");
        check_eq("t6.count0", 32'(r_count), 0);
        check_eq("t6.f.valid0", 32'(f_rd_valid), 0);
        cycle("t6.new_wr", 1, 8'h77, 0, 0);
        check_eq("t6.f.new", 32'(f_rd_data), 32'h77);
        cycle("t6.new_rd", 0, 8'h00, 1, 0);
        check_eq("t6.r.new", 32'(r_rd_data), 32'h77);

        // Random traffic with shifting write/read bias
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            int wp;
            int rp;
            wp = ((i / 100) % 2 == 0) ? 70 : 30;
            rp = 100 - wp;
            if ($urandom_range(0, 299) == 0) begin
                async_reset("rnd.arst");
            end else begin
                cycle("rnd", $urandom_range(0, 99) < wp, 8'($urandom),
                      $urandom_range(0, 99) < rp, $urandom_range(0, 63) == 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
